// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - response codes, FSM state types and address decode helper for the AXI4-Lite register file
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {WR_COLLECT, WR_RESP} wr_state_e;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

   // An address hits the bank only when every bit above the register index is zero.
   function automatic logic addr_in_range(input logic [31:0] addr, input int idx_w);
      return (addr >> (idx_w + 2)) == 32'd0;
   endfunction

endpackage

// File: rtl/axil_reg_array.sv
// rtl/axil_reg_array.sv - NUM_REGS x 32-bit register storage with byte-strobe writes and flattened export
module axil_reg_array #(
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [IDX_W-1:0]         widx,
   input  logic [3:0]               wstrb,
   input  logic [31:0]              wdata,
   input  logic [IDX_W-1:0]         ridx,
   output logic [31:0]              rdata,
   output logic [32*NUM_REGS-1:0]   regs_flat
);

   logic [31:0] mem [NUM_REGS];

   // Storage: clear on reset, otherwise update only the strobed bytes of the addressed register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_REGS; k++) mem[k] <= '0;
      end else if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Read port is combinational so a capture on the commit edge sees the pre-write contents.
   assign rdata = mem[ridx];

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign regs_flat[32*k +: 32] = mem[k];
   end

endmodule

// File: rtl/axil_slave_regfile.sv
// rtl/axil_slave_regfile.sv - AXI4-Lite register file responder; AXIL_SLV_DECERR_EN selects DECERR for unmapped addresses
module axil_slave_regfile
   import axil_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              S_AXI_AWADDR,
   input  logic                     S_AXI_AWVALID,
   output logic                     S_AXI_AWREADY,
   input  logic [31:0]              S_AXI_WDATA,
   input  logic [3:0]               S_AXI_WSTRB,
   input  logic                     S_AXI_WVALID,
   output logic                     S_AXI_WREADY,
   output logic [1:0]               S_AXI_BRESP,
   output logic                     S_AXI_BVALID,
   input  logic                     S_AXI_BREADY,
   input  logic [31:0]              S_AXI_ARADDR,
   input  logic                     S_AXI_ARVALID,
   output logic                     S_AXI_ARREADY,
   output logic [31:0]              S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY,
   output logic [32*NUM_REGS-1:0]   regs_q,
   output logic                     wr_pulse,
   output logic [IDX_W-1:0]         wr_idx
);

`ifdef AXIL_SLV_DECERR_EN
   localparam logic [1:0] RESP_UNMAPPED = RESP_DECERR;
`else
   localparam logic [1:0] RESP_UNMAPPED = RESP_SLVERR;
`endif

   logic             init_done;
   wr_state_e        wr_state;
   rd_state_e        rd_state;

   logic             aw_held;
   logic [IDX_W-1:0] aw_idx;
   logic             aw_ok;
   logic             w_held;
   logic [31:0]      w_data;
   logic [3:0]       w_strb;
   logic [1:0]       b_resp;

   logic             ar_held;
   logic [IDX_W-1:0] ar_idx;
   logic             ar_ok;
   logic [31:0]      r_data;
   logic [1:0]       r_resp;

   logic             commit;
   logic [31:0]      arr_rdata;

   // Byte offset bits never take part in decode.
   logic             unused_addr_lsbs;
   assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign S_AXI_AWREADY = init_done && (wr_state == WR_COLLECT) && !aw_held;
   assign S_AXI_WREADY  = init_done && (wr_state == WR_COLLECT) && !w_held;
   assign S_AXI_BVALID  = (wr_state == WR_RESP);
   assign S_AXI_BRESP   = b_resp;
   assign S_AXI_ARREADY = init_done && (rd_state == RD_IDLE) && !ar_held;
   assign S_AXI_RVALID  = (rd_state == RD_DATA);
   assign S_AXI_RDATA   = r_data;
   assign S_AXI_RRESP   = r_resp;

   assign commit = (wr_state == WR_COLLECT) && aw_held && w_held;

   // Keep all readies low until the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) init_done <= 1'b0;
      else     init_done <= 1'b1;
   end

   // Write channel: collect AW and W independently, commit once both are held, then hold B until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_state <= WR_COLLECT;
         aw_held  <= 1'b0;
         aw_idx   <= '0;
         aw_ok    <= 1'b0;
         w_held   <= 1'b0;
         w_data   <= '0;
         w_strb   <= '0;
         b_resp   <= RESP_OKAY;
         wr_pulse <= 1'b0;
         wr_idx   <= '0;
      end else begin
         wr_pulse <= 1'b0;
         if (wr_state == WR_COLLECT) begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
               aw_held <= 1'b1;
               aw_idx  <= S_AXI_AWADDR[IDX_W+1:2];
               aw_ok   <= addr_in_range(S_AXI_AWADDR, IDX_W);
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
               w_held <= 1'b1;
               w_data <= S_AXI_WDATA;
               w_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
               wr_state <= WR_RESP;
               b_resp   <= aw_ok ? RESP_OKAY : RESP_UNMAPPED;
               wr_pulse <= aw_ok;
               if (aw_ok) wr_idx <= aw_idx;
            end
         end else if (S_AXI_BREADY) begin
            wr_state <= WR_COLLECT;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
         end
      end
   end

   // Read channel: latch AR, capture data on the following edge, hold R until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state <= RD_IDLE;
         ar_held  <= 1'b0;
         ar_idx   <= '0;
         ar_ok    <= 1'b0;
         r_data   <= '0;
         r_resp   <= RESP_OKAY;
      end else if (rd_state == RD_IDLE) begin
         if (ar_held) begin
            rd_state <= RD_DATA;
            r_data   <= ar_ok ? arr_rdata : 32'd0;
            r_resp   <= ar_ok ? RESP_OKAY : RESP_UNMAPPED;
         end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            ar_held <= 1'b1;
            ar_idx  <= S_AXI_ARADDR[IDX_W+1:2];
            ar_ok   <= addr_in_range(S_AXI_ARADDR, IDX_W);
         end
      end else if (S_AXI_RREADY) begin
         rd_state <= RD_IDLE;
         ar_held  <= 1'b0;
      end
   end

   axil_reg_array #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_reg_array (
      .clk       (clk),
      .rst       (rst),
      .we        (commit && aw_ok),
      .widx      (aw_idx),
      .wstrb     (w_strb),
      .wdata     (w_data),
      .ridx      (ar_idx),
      .rdata     (arr_rdata),
      .regs_flat (regs_q)
   );

endmodule

// File: tb/tb_axil_slave_regfile.sv
// tb/tb_axil_slave_regfile.sv - randomized self-checking bench for axil_slave_regfile against an array model
module tb_axil_slave_regfile;

   localparam int NUM_REGS = 16;
   localparam int IDX_W    = 4;
`ifdef AXIL_SLV_DECERR_EN
   localparam logic [1:0] ERR_RESP = 2'b11;
`else
   localparam logic [1:0] ERR_RESP = 2'b10;
`endif

   logic                   clk;
   logic                   rst;
   logic [31:0]            S_AXI_AWADDR;
   logic                   S_AXI_AWVALID;
   logic                   S_AXI_AWREADY;
   logic [31:0]            S_AXI_WDATA;
   logic [3:0]             S_AXI_WSTRB;
   logic                   S_AXI_WVALID;
   logic                   S_AXI_WREADY;
   logic [1:0]             S_AXI_BRESP;
   logic                   S_AXI_BVALID;
   logic                   S_AXI_BREADY;
   logic [31:0]            S_AXI_ARADDR;
   logic                   S_AXI_ARVALID;
   logic                   S_AXI_ARREADY;
   logic [31:0]            S_AXI_RDATA;
   logic [1:0]             S_AXI_RRESP;
   logic                   S_AXI_RVALID;
   logic                   S_AXI_RREADY;
   logic [32*NUM_REGS-1:0] regs_q;
   logic                   wr_pulse;
   logic [IDX_W-1:0]       wr_idx;

   logic [31:0] model [NUM_REGS];
   int n_checks = 0;
   int n_fail   = 0;

   axil_slave_regfile #(.NUM_REGS(NUM_REGS)) dut (
      .clk           (clk),
      .rst           (rst),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .regs_q        (regs_q),
      .wr_pulse      (wr_pulse),
      .wr_idx        (wr_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int k = 0; k < NUM_REGS; k++) check(tag, regs_q[32*k +: 32], model[k]);
   endtask

   function automatic bit in_map(input logic [31:0] addr);
      return addr < 32'(NUM_REGS * 4);
   endfunction

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
      int cyc = 0;
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int idx = int'(addr[5:2]);
      bit ok = in_map(addr);
      while (!(aw_done && w_done) && cyc < 64) begin
         S_AXI_AWADDR  = addr;
         S_AXI_WDATA   = data;
         S_AXI_WSTRB   = strb;
         S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
         S_AXI_WVALID  = !w_done && (cyc >= w_dly);
         if (w_done && !aw_done) check("wready_while_w_held", S_AXI_WREADY, 0);
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         @(posedge clk);
         @(negedge clk);
         aw_done |= aw_hs;
         w_done  |= w_hs;
         cyc++;
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      check("aw_w_handshake", aw_done && w_done, 1);
      check("bvalid_before_commit", S_AXI_BVALID, 0);
      check("wr_pulse_before_commit", wr_pulse, 0);
      @(negedge clk);
      if (ok) for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      check("bvalid", S_AXI_BVALID, 1);
      check("bresp", S_AXI_BRESP, ok ? 2'b00 : ERR_RESP);
      check("wr_pulse", wr_pulse, ok);
      if (ok) check("wr_idx", wr_idx, idx);
      check_regs("regs_after_write");
      for (int i = 0; i < b_dly; i++) begin
         @(negedge clk);
         check("bvalid_hold", S_AXI_BVALID, 1);
         check("bresp_hold", S_AXI_BRESP, ok ? 2'b00 : ERR_RESP);
         check("wr_pulse_single", wr_pulse, 0);
         check("awready_in_resp", S_AXI_AWREADY, 0);
      end
      S_AXI_BREADY = 1'b1;
      @(negedge clk);
      S_AXI_BREADY = 1'b0;
      check("bvalid_cleared", S_AXI_BVALID, 0);
      check("awready_back", S_AXI_AWREADY, 1);
      check("wready_back", S_AXI_WREADY, 1);
   endtask

   task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
      int cyc = 0;
      bit done = 0, hs;
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      while (!done && cyc < 64) begin
         S_AXI_ARADDR  = addr;
         S_AXI_ARVALID = (cyc >= ar_dly);
         hs = S_AXI_ARVALID && S_AXI_ARREADY;
         @(posedge clk);
         @(negedge clk);
         done = hs;
         cyc++;
      end
      S_AXI_ARVALID = 1'b0;
      check("ar_handshake", done, 1);
      check("rvalid_early", S_AXI_RVALID, 0);
      check("arready_after_hs", S_AXI_ARREADY, 0);
      exp_d = in_map(addr) ? model[addr[5:2]] : 32'd0;
      exp_r = in_map(addr) ? 2'b00 : ERR_RESP;
      @(negedge clk);
      check("rvalid", S_AXI_RVALID, 1);
      check("rdata", S_AXI_RDATA, exp_d);
      check("rresp", S_AXI_RRESP, exp_r);
      for (int i = 0; i < r_dly; i++) begin
         @(negedge clk);
         check("rvalid_hold", S_AXI_RVALID, 1);
         check("rdata_hold", S_AXI_RDATA, exp_d);
         check("rresp_hold", S_AXI_RRESP, exp_r);
         check("arready_in_data", S_AXI_ARREADY, 0);
      end
      S_AXI_RREADY = 1'b1;
      @(negedge clk);
      S_AXI_RREADY = 1'b0;
      check("rvalid_cleared", S_AXI_RVALID, 0);
      check("arready_back", S_AXI_ARREADY, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] addr;
      int sel;
      rst = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
      S_AXI_WVALID = 0;  S_AXI_BREADY = 0;  S_AXI_ARADDR = '0; S_AXI_ARVALID = 0;
      S_AXI_RREADY = 0;
      for (int k = 0; k < NUM_REGS; k++) model[k] = '0;

      repeat (3) @(negedge clk);
      check("rst_awready", S_AXI_AWREADY, 0);
      check("rst_wready", S_AXI_WREADY, 0);
      check("rst_arready", S_AXI_ARREADY, 0);
      check("rst_bvalid", S_AXI_BVALID, 0);
      check("rst_rvalid", S_AXI_RVALID, 0);
      check("rst_wr_pulse", wr_pulse, 0);
      check("rst_rdata", S_AXI_RDATA, 0);
      check("rst_wr_idx", wr_idx, 0);
      check_regs("rst_regs");
      rst = 1'b0;
      #1;
      check("awready_before_edge", S_AXI_AWREADY, 0);
      @(negedge clk);
      check("awready_first_edge", S_AXI_AWREADY, 1);
      check("arready_first_edge", S_AXI_ARREADY, 1);

      do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 1);
      check("reg1_full", regs_q[63:32], 32'hDEADBEEF);
      do_write(32'h04, 32'h11223344, 4'b0101, 3, 0, 0);
      check("reg1_strobed", regs_q[63:32], 32'hDE22BE44);
      do_read(32'h04, 0, 5);
      do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 1, 0);
      do_read(32'h40, 1, 2);
      do_write(32'h0C, 32'h12345678, 4'h0, 0, 0, 0);

      // Read capture and write commit land on the same edge for reg 2.
      S_AXI_AWADDR = 32'h08; S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF;
      S_AXI_ARADDR = 32'h08;
      S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
      check("same_edge_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
      @(negedge clk);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
      @(negedge clk);
      check("same_edge_bvalid", S_AXI_BVALID, 1);
      check("same_edge_rvalid", S_AXI_RVALID, 1);
      check("same_edge_rdata_old", S_AXI_RDATA, 32'h0);
      model[2] = 32'hA5A5A5A5;
      check_regs("same_edge_regs");
      S_AXI_BREADY = 1; S_AXI_RREADY = 1;
      @(negedge clk);
      S_AXI_BREADY = 0; S_AXI_RREADY = 0;
      do_read(32'h08, 0, 0);

      for (int i = 0; i < 60; i++) begin
         sel  = int'($urandom_range(0, 9));
         addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) addr = addr | (32'h40 << $urandom_range(0, 25));
         if (sel < 5)
            do_write(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         else
            do_read(addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Reset while a write response is pending.
      S_AXI_AWADDR = 32'h10; S_AXI_WDATA = 32'h0BADF00D; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
      @(negedge clk);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
      @(negedge clk);
      check("pre_reset_bvalid", S_AXI_BVALID, 1);
      rst = 1'b1;
      #1;
      for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
      check("reset_bvalid", S_AXI_BVALID, 0);
      check("reset_awready", S_AXI_AWREADY, 0);
      check_regs("reset_regs");
      S_AXI_BREADY = 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      S_AXI_BREADY = 0;
      @(negedge clk);
      check("post_reset_awready", S_AXI_AWREADY, 1);
      check("post_reset_wready", S_AXI_WREADY, 1);
      repeat (3) begin
         @(negedge clk);
         check("no_stale_b", S_AXI_BVALID, 0);
      end
      do_write(32'h3C, 32'h5A5A0001, 4'hF, 1, 0, 0);
      do_read(32'h3C, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axil_slave_regfile.md
# axil_slave_regfile

AXI4-Lite responder exposing a bank of NUM_REGS 32-bit read/write registers with byte-strobe writes. Sits at the slave end of the master interface that drives the peripheral bus; it accepts write address/data in any order, commits writes, issues write responses, and serves single-beat reads. Register contents are exported in parallel to the fabric as control outputs.

## Interface
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256
- IDX_W, $clog2(NUM_REGS), register index width (derived, not overridden)
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-high
- S_AXI_AWADDR  in  32  write address
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables; bit i gates WDATA[8i+7:8i]
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
- S_AXI_ARADDR  in  32  read address
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
- regs_q  out  32*NUM_REGS  flattened register contents, reg k at [32k+31:32k]
- wr_pulse  out  1  one-cycle strobe on each committed in-range write
- wr_idx  out  IDX_W  index of the register written, valid with wr_pulse

## Operation
- Decode: index = ADDR[IDX_W+1:2]; ADDR[1:0] ignored; in range iff ADDR[31:IDX_W+2] == 0.
- Write FSM WR_COLLECT -> WR_RESP -> WR_COLLECT. In WR_COLLECT, AW and W are latched independently into one-entry holding registers; AWREADY = !aw_held, WREADY = !w_held. The edge after both are held: commit, BVALID=1, state WR_RESP. Same-cycle AW+W handshake is legal; commit follows next edge.
- Commit: only bytes with WSTRB=1 updated; WSTRB=0000 is a legal no-op returning OKAY with wr_pulse=1. Out-of-range: no register change, wr_pulse=0, BRESP=SLVERR (2'b10).
- WR_RESP: AWREADY=WREADY=0; BVALID, BRESP held until BREADY; holding registers clear on B handshake, readies return next cycle.
- Read FSM RD_IDLE -> RD_DATA -> RD_IDLE. ARREADY=1 in RD_IDLE. On AR handshake, RDATA/RRESP registered, RVALID=1 next edge. Out-of-range: RDATA=0, RRESP=SLVERR. RDATA/RRESP stable until R handshake; ARREADY=0 in RD_DATA.
- Read and write channels independent; read capture and write commit on the same edge to the same register returns the pre-write value.
- Reset mid-transaction: all FSMs to idle, holding registers cleared, registers zeroed; no response issued for the aborted transaction.

## Timing
- Reset values: AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse 0; BRESP, RRESP, RDATA, regs_q, wr_idx 0. Readies rise on first clk edge after rst deasserts.
- Write latency: later of AW/W handshake at edge N -> regs_q, wr_pulse, BVALID updated at edge N+1.
- Read latency: AR handshake at edge N -> RVALID at edge N+1.
- Back-to-back: B handshake at edge M -> AWREADY/WREADY high after M; next commit no earlier than M+2. Same for reads.
- All outputs registered or decoded from registered state only; no combinational path from any VALID/READY input to any output.

## Configuration
- AXIL_SLV_DECERR_EN defined: out-of-range reads/writes answer DECERR (2'b11). Undefined: SLVERR (2'b10). No other behavioural difference.

## Structure
- Package axil_pkg: response constants RESP_OKAY 2'b00, RESP_SLVERR 2'b10, RESP_DECERR 2'b11; wr_state_e {WR_COLLECT, WR_RESP}; rd_state_e {RD_IDLE, RD_DATA}.
- Sub-module axil_reg_array: NUM_REGS×32 storage with write enable, index, strobe, data; async-reset to 0; combinational read by index plus flattened output.

## Test plan
- Write 0xDEADBEEF to 0x04, WSTRB=F, AW and W same cycle -> BVALID one cycle later, BRESP=00, regs_q[63:32]=0xDEADBEEF, wr_pulse=1, wr_idx=1.
- W three cycles before AW, WSTRB=0101, data 0x11223344 over 0xDEADBEEF at 0x04 -> reg1=0xDE22BE44, WREADY low while W held.
- Read 0x04 with RREADY low 5 cycles -> RVALID, RDATA=0xDE22BE44, RRESP=00 stable throughout; ARREADY low until handshake.
- Write/read address 0x40 (NUM_REGS=16) -> no register changes, wr_pulse=0, BRESP/RRESP=10 (11 with AXIL_SLV_DECERR_EN), RDATA=0.
- Same-edge read capture and write commit to reg 2 (old 0x0, new 0xA5A5A5A5) -> RDATA=0x0, subsequent read 0xA5A5A5A5.
- Assert rst while BVALID pending -> BVALID, regs_q to 0 immediately; readies return after rst release; no stale B issued.
